// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: two-flop sync, stable-time filter, press/release ticks
// and long-press detection driven by a shared millisecond prescaler.
module debouncer_multi #(
    parameter int NumCh        = 4,
    parameter int ClkFreq      = 100_000_000,
    parameter int StableTimeUs = 10_000,
    parameter int LongPressMs  = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] sw_i,
    output logic [NumCh-1:0] db_level_o,
    output logic [NumCh-1:0] rise_tick_o,
    output logic [NumCh-1:0] fall_tick_o,
    output logic [NumCh-1:0] long_tick_o,
    output logic [NumCh-1:0] long_level_o
);

    localparam int CntMax = (ClkFreq / 1_000_000) * StableTimeUs;
    localparam int CntW   = $clog2(CntMax);
    localparam int PreMax = ClkFreq / 1000;
    localparam int PreW   = $clog2(PreMax);
    localparam int HoldW  = $clog2(LongPressMs + 1);

    localparam logic [CntW-1:0]  CntLast  = CntW'(CntMax - 1);
    localparam logic [PreW-1:0]  PreLast  = PreW'(PreMax - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LongPressMs);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressMs - 1);

    logic [NumCh-1:0] r_sync1;
    logic [NumCh-1:0] r_sync2;
    logic [PreW-1:0]  r_pre;
    logic             w_ms_tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler; its phase is unrelated to any press, hence +0/-1 ms resolution.
    assign w_ms_tick = (r_pre == PreLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pre <= '0;
        end else if (w_ms_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    for (genvar n = 0; n < NumCh; n++) begin : g_ch
        logic [CntW-1:0]  r_cnt;
        logic [HoldW-1:0] r_hold;
        logic             r_db;
        logic             r_rise;
        logic             r_fall;
        logic             r_long_tick;
        logic             r_long_lvl;
        logic             w_flip;

        // Synchronised input has disagreed with the level for CntMax consecutive clocks.
        assign w_flip = (r_sync2[n] != r_db) && (r_cnt == CntLast);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt  <= '0;
                r_db   <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (r_sync2[n] == r_db) begin
                    r_cnt <= '0;
                end else if (!w_flip) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_db   <= r_sync2[n];
                    r_cnt  <= '0;
                    r_rise <= r_sync2[n];
                    r_fall <= ~r_sync2[n];
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_hold      <= '0;
                r_long_tick <= 1'b0;
                r_long_lvl  <= 1'b0;
            end else begin
                r_long_tick <= 1'b0;
                if (!r_db) begin
                    r_hold <= '0;
                end else if (w_ms_tick && (r_hold != HoldMax)) begin
                    r_hold <= r_hold + 1'b1;
                end
                // A release committing on the same clock wins over a long press.
                if (r_db && w_ms_tick && (r_hold == HoldLast) && !w_flip) begin
                    r_long_tick <= 1'b1;
                    r_long_lvl  <= 1'b1;
                end
                if (r_db && w_flip) begin
                    r_long_lvl <= 1'b0;
                end
            end
        end

        assign db_level_o[n]   = r_db;
        assign rise_tick_o[n]  = r_rise;
        assign fall_tick_o[n]  = r_fall;
        assign long_tick_o[n]  = r_long_tick;
        assign long_level_o[n] = r_long_lvl;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: latency, bounce rejection, release, long press, reset.
module tb_debouncer_multi;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] sw_i;
    logic [3:0] db_level_o;
    logic [3:0] rise_tick_o;
    logic [3:0] fall_tick_o;
    logic [3:0] long_tick_o;
    logic [3:0] long_level_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rise1  = 0;
    int n_long2  = 0;
    int long_at  = 0;

    debouncer_multi #(
        .NumCh(4),
        .ClkFreq(10_000_000),
        .StableTimeUs(1),
        .LongPressMs(3)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .sw_i(sw_i),
        .db_level_o(db_level_o),
        .rise_tick_o(rise_tick_o),
        .fall_tick_o(fall_tick_o),
        .long_tick_o(long_tick_o),
        .long_level_o(long_level_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!rst_i && rise_tick_o[1]) n_rise1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        sw_i  = 4'b0000;
        wait_neg(3);
        rst_i = 1'b0;

        // 1: idle inputs keep every output low
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            check("idle_outputs", {12'd0, db_level_o, rise_tick_o, fall_tick_o,
                                   long_tick_o, long_level_o}, 32'd0);
        end

        // 2: channel 0 press, level on 12th sampling edge
        sw_i[0] = 1'b1;
        wait_neg(11);
        check("ch0_level_before", {28'd0, db_level_o}, 32'h0);
        wait_neg(1);
        check("ch0_level_at12", {28'd0, db_level_o}, 32'h1);
        check("ch0_rise_at12", {28'd0, rise_tick_o}, 32'h1);
        check("ch0_fall_at12", {28'd0, fall_tick_o}, 32'h0);
        wait_neg(1);
        check("ch0_rise_after", {28'd0, rise_tick_o}, 32'h0);
        check("ch0_level_after", {28'd0, db_level_o}, 32'h1);

        // 3: channel 1 bounce 9 high / 1 low / held high
        sw_i[1] = 1'b1;
        wait_neg(9);
        sw_i[1] = 1'b0;
        wait_neg(1);
        sw_i[1] = 1'b1;
        check("ch1_no_level_bounce", {31'd0, db_level_o[1]}, 32'h0);
        wait_neg(11);
        check("ch1_level_before", {31'd0, db_level_o[1]}, 32'h0);
        wait_neg(1);
        check("ch1_level_at12", {28'd0, db_level_o}, 32'h3);
        check("ch1_rise_at12", {28'd0, rise_tick_o}, 32'h2);
        wait_neg(5);
        check("ch1_rise_count", n_rise1, 32'd1);
        sw_i[1] = 1'b0;
        wait_neg(20);
        check("ch1_released", {31'd0, db_level_o[1]}, 32'h0);

        // 4: channel 0 release, short press gives no long press
        sw_i[0] = 1'b0;
        wait_neg(11);
        check("ch0_fall_before", {28'd0, fall_tick_o}, 32'h0);
        check("ch0_level_held", {31'd0, db_level_o[0]}, 32'h1);
        wait_neg(1);
        check("ch0_level_fallen", {31'd0, db_level_o[0]}, 32'h0);
        check("ch0_fall_at12", {28'd0, fall_tick_o}, 32'h1);
        check("ch0_long_level", {28'd0, long_level_o}, 32'h0);
        wait_neg(1);
        check("ch0_fall_after", {28'd0, fall_tick_o}, 32'h0);

        // 5: channel 2 held 40000 clocks for a long press
        sw_i[2] = 1'b1;
        wait_neg(12);
        check("ch2_level_rise", {31'd0, db_level_o[2]}, 32'h1);
        for (int i = 1; i <= 40_000 - 12; i++) begin
            @(negedge clk_i);
            if (long_tick_o[2]) begin
                n_long2++;
                long_at = i;
                check("ch2_long_level_with_tick", {31'd0, long_level_o[2]}, 32'h1);
            end
        end
        check("ch2_long_count", n_long2, 32'd1);
        check("ch2_long_window", ((long_at >= 20_000) && (long_at <= 30_000)) ? 32'd1 : 32'd0,
              32'd1);
        check("ch2_long_level_held", {28'd0, long_level_o}, 32'h4);
        sw_i[2] = 1'b0;
        wait_neg(11);
        check("ch2_long_level_pre_fall", {31'd0, long_level_o[2]}, 32'h1);
        wait_neg(1);
        check("ch2_fall_tick", {28'd0, fall_tick_o}, 32'h4);
        check("ch2_long_level_cleared", {28'd0, long_level_o}, 32'h0);
        wait_neg(10);
        check("all_low_before_rst", {28'd0, db_level_o}, 32'h0);

        // 6: all channels pressed, reset mid-count, full latency afterwards
        sw_i = 4'b1111;
        wait_neg(7);
        rst_i = 1'b1;
        #1;
        check("rst_outputs_zero", {12'd0, db_level_o, rise_tick_o, fall_tick_o,
                                   long_tick_o, long_level_o}, 32'd0);
        wait_neg(2);
        rst_i = 1'b0;
        wait_neg(11);
        check("post_rst_level_before", {28'd0, db_level_o}, 32'h0);
        wait_neg(1);
        check("post_rst_level_at12", {28'd0, db_level_o}, 32'hF);
        check("post_rst_rise_all", {28'd0, rise_tick_o}, 32'hF);
        wait_neg(1);
        check("post_rst_rise_after", {28'd0, rise_tick_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
